// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding and instruction constants for proc_core
package cpu_pkg;
  typedef enum logic [2:0] {F_REQ, F_WAIT, EXEC, D_WAIT, O_WAIT, HALT} state_t;
  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_OUTM = 5'b00001;
  localparam logic [4:0] OP_OUTR = 5'b00010;
  localparam logic [4:0] OP_LDR  = 5'b00011;
  localparam logic [4:0] OP_STR  = 5'b00100;
  localparam logic [4:0] OP_ADD  = 5'b00101;
  localparam logic [4:0] OP_JMP  = 5'b00111;
  localparam logic [4:0] OP_JNZ  = 5'b01000;
  localparam logic [2:0] LDI_PFX = 3'b110;
  localparam logic [15:0] HALT_WORD = 16'h7777;
endpackage

// File: rtl/proc_regfile.sv
// proc_regfile: GPR file, one write port, two combinational read ports, async clear
module proc_regfile #(
  parameter int DATA_W = 8,
  parameter int REG_COUNT = 32,
  localparam int RI = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RI-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RI-1:0]     ra,
  output logic [DATA_W-1:0] rda,
  input  logic [RI-1:0]     rb,
  output logic [DATA_W-1:0] rdb
);
  localparam int N = 1 << RI;
  logic [DATA_W-1:0] regs [N];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < N; i++) regs[i] <= '0;
    else if (we) regs[waddr] <= wdata;
  assign rda = regs[ra];
  assign rdb = regs[rb];
endmodule

// File: rtl/proc_core.sv
// proc_core: multi-cycle 16-bit-instruction core with req/ack memory and valid/ready output port
module proc_core import cpu_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int REG_COUNT = 32,
  parameter int PC_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [15:0]       out_data,
  input  logic              out_ready,
  output logic              halted,
  output logic              illegal
);
  localparam int RI = $clog2(REG_COUNT);
  state_t state;
  logic [PC_W-1:0] pc, pc_inc;
  logic [15:0] ir;
  logic [4:0] op;
  logic is_halt, is_ldi, rf_we;
  logic [RI-1:0] ra, waddr;
  logic [DATA_W-1:0] rda, rdb, wdata;
  assign op = ir[15:11];
  assign is_halt = ir == HALT_WORD;
  assign is_ldi = ir[15:13] == LDI_PFX;
  assign pc_inc = pc + PC_W'(1);
  assign ra = op == OP_JNZ ? ir[6 +: RI] : ir[5 +: RI];
  assign waddr = is_ldi ? ir[8 +: RI] : ir[5 +: RI];
  assign rf_we = (state == EXEC && (is_ldi || op == OP_ADD)) || (state == D_WAIT && mem_ack && op == OP_LDR);
  assign wdata = is_ldi ? DATA_W'(ir[7:0]) : op == OP_ADD ? rda + rdb : mem_rdata[DATA_W-1:0];
  proc_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_rf (
    .clk(clk), .rst(rst), .we(rf_we), .waddr(waddr), .wdata(wdata),
    .ra(ra), .rda(rda), .rb(ir[RI-1:0]), .rdb(rdb)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= F_REQ;
      pc <= '0;
      ir <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      halted <= 1'b0;
      illegal <= 1'b0;
    end else
      case (state)
        F_REQ: begin
          mem_req <= 1'b1;
          mem_we <= 1'b0;
          mem_addr <= ADDR_W'(pc);
          state <= F_WAIT;
        end
        F_WAIT: if (mem_ack) begin
          ir <= mem_rdata;
          mem_req <= 1'b0;
          state <= EXEC;
        end
        EXEC:
          if (is_halt) begin
            halted <= 1'b1;
            state <= HALT;
          end else if (is_ldi || op == OP_ADD || op == OP_NOP) begin
            pc <= pc_inc;
            state <= F_REQ;
          end else if (op == OP_JMP) begin
            pc <= PC_W'(ir[10:0]);
            state <= F_REQ;
          end else if (op == OP_JNZ) begin
            pc <= rda != '0 ? PC_W'(ir[5:0]) : pc_inc;
            state <= F_REQ;
          end else if (op == OP_OUTM || op == OP_LDR || op == OP_STR) begin
            mem_req <= 1'b1;
            mem_we <= op == OP_STR;
            mem_addr <= op == OP_OUTM ? ADDR_W'(ir[10:0]) : ADDR_W'(rdb);
            mem_wdata <= 16'(rda);
            state <= D_WAIT;
          end else if (op == OP_OUTR) begin
            out_valid <= 1'b1;
            out_data <= 16'(rdb);
            state <= O_WAIT;
          end else begin
            illegal <= 1'b1;
            halted <= 1'b1;
            state <= HALT;
          end
        D_WAIT: if (mem_ack) begin
          mem_req <= 1'b0;
          if (op == OP_OUTM) begin
            out_data <= mem_rdata;
            out_valid <= 1'b1;
            state <= O_WAIT;
          end else begin
            pc <= pc_inc;
            state <= F_REQ;
          end
        end
        O_WAIT: if (out_ready) begin
          out_valid <= 1'b0;
          pc <= pc_inc;
          state <= F_REQ;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_proc_core.sv
// tb_proc_core: directed program tests of proc_core with a shared behavioural memory
module tb_proc_core;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [15:0] mem [256];
  logic ld_en = 0, clr = 0;
  logic [7:0] ld_a = 0;
  logic [15:0] ld_d = 0;
  int ack_dly = 0, cnt = 0, total = 0, passes = 0, viol = 0, f2 = 0, o0_cnt = 0, d1_cnt = 0;
  logic [15:0] o0_last = 0, d1_last = 0;
  logic m0_req, m0_we, m0_ack, o0_valid, o0_ready = 1, h0, i0;
  logic [15:0] m0_addr, m0_wdata, m0_rdata, o0_data;
  logic m1_req, m1_we, o1_valid, h1, i1;
  logic [15:0] m1_addr, m1_wdata, m1_rdata, o1_data;
  logic m2_req, m2_we, o2_valid, h2, i2;
  logic [15:0] m2_addr, m2_wdata, m2_rdata, o2_data;
  logic pw = 0, ow = 0, pwe = 0;
  logic [15:0] pa = 0, pd = 0, pod = 0;

  assign m0_ack = m0_req && (cnt >= ack_dly);
  assign m0_rdata = mem[m0_addr[7:0]];
  assign m1_rdata = mem[m1_addr[7:0]];
  assign m2_rdata = mem[m2_addr[7:0]];

  proc_core u0 (.clk(clk), .rst(rst), .mem_req(m0_req), .mem_we(m0_we), .mem_addr(m0_addr),
    .mem_wdata(m0_wdata), .mem_rdata(m0_rdata), .mem_ack(m0_ack), .out_valid(o0_valid),
    .out_data(o0_data), .out_ready(o0_ready), .halted(h0), .illegal(i0));
  proc_core #(.DATA_W(16)) u1 (.clk(clk), .rst(rst), .mem_req(m1_req), .mem_we(m1_we),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata), .mem_ack(m1_req),
    .out_valid(o1_valid), .out_data(o1_data), .out_ready(1'b1), .halted(h1), .illegal(i1));
  proc_core #(.PC_W(4)) u2 (.clk(clk), .rst(rst), .mem_req(m2_req), .mem_we(m2_we),
    .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_rdata(m2_rdata), .mem_ack(m2_req),
    .out_valid(o2_valid), .out_data(o2_data), .out_ready(1'b1), .halted(h2), .illegal(i2));

  always @(posedge clk)
    if (clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (ld_en) mem[ld_a] <= ld_d;
    else if (m0_req && m0_ack && m0_we) mem[m0_addr[7:0]] <= m0_wdata;

  always @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 0;
      f2 <= 0;
      o0_cnt <= 0;
      d1_cnt <= 0;
      pw <= 0;
      ow <= 0;
    end else begin
      cnt <= (m0_req && !m0_ack) ? cnt + 1 : 0;
      if (m0_req && m0_ack && !m0_we && m0_addr == 16'd2) f2 <= f2 + 1;
      if (o0_valid && o0_ready) begin o0_cnt <= o0_cnt + 1; o0_last <= o0_data; end
      if (o1_valid) begin d1_cnt <= d1_cnt + 1; d1_last <= o1_data; end
      // handshake invariants: held request fields, held output word, exclusive req/valid, silence when halted
      if (pw && (!m0_req || m0_addr != pa || m0_we != pwe || m0_wdata != pd)) viol <= viol + 1;
      if (ow && (!o0_valid || o0_data != pod)) viol <= viol + 1;
      if ((m0_req && o0_valid) || (h0 && m0_req)) viol <= viol + 1;
      pw <= m0_req && !m0_ack;
      pa <= m0_addr;
      pwe <= m0_we;
      pd <= m0_wdata;
      ow <= o0_valid && !o0_ready;
      pod <= o0_data;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    ld_en = 1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!h0 && n < 400) begin @(negedge clk); n++; end
    chk(tag, {31'd0, h0}, 1);
  endtask

  task automatic start();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    chk("reset_flags", {m0_req, m0_we, o0_valid, h0, i0}, 0);
    chk("reset_addr", m0_addr, 0);
    chk("reset_data", {o0_data, m0_wdata}, 0);
    // LDI r3,0xA5 / OUTR r3 / HALT: 3+4+3 edges to halted
    poke(0, 16'hC3A5); poke(1, 16'h1003); poke(2, 16'h7777);
    rst = 0;
    repeat (9) @(posedge clk);
    #1 chk("halt_early", {31'd0, h0}, 0);
    @(posedge clk);
    #1 chk("halt_cycle", {31'd0, h0}, 1);
    chk("outr_count", o0_cnt, 1);
    chk("outr_data", o0_last, 16'h00A5);
    // OUTM 0x040 with three wait cycles on every request
    @(negedge clk); rst = 1;
    poke(0, 16'h0840); poke(1, 16'h7777); poke(8'h40, 16'h1234);
    ack_dly = 3;
    start();
    begin
      int n = 0;
      while (!(m0_req && m0_addr == 16'h0040) && n < 100) begin @(negedge clk); n++; end
      for (int k = 0; k < 3; k++) begin
        chk("outm_addr", m0_addr, 16'h0040);
        chk("outm_req", {m0_req, m0_we, m0_ack}, 3'b100);
        @(negedge clk);
      end
    end
    wait_halt("outm_halt");
    chk("outm_count", o0_cnt, 1);
    chk("outm_data", o0_last, 16'h1234);
    // ADD wrap in 8 bits vs. carry kept in 16 bits
    rst = 1; ack_dly = 0;
    poke(0, 16'hC1F0); poke(1, 16'hC220); poke(2, 16'h2822); poke(3, 16'h1001); poke(4, 16'h7777);
    start();
    begin
      int n = 0;
      while (!(h0 && h1) && n < 100) begin @(negedge clk); n++; end
    end
    chk("add8", o0_last, 16'h0010);
    chk("add16_halt", {31'd0, h1}, 1);
    chk("add16", d1_last, 16'h0110);
    chk("add16_count", d1_cnt, 1);
    // countdown: JNZ back to address 2 taken twice, then r1 emitted
    rst = 1;
    poke(0, 16'hC103); poke(1, 16'hC2FF); poke(2, 16'h2822); poke(3, 16'h4042);
    poke(4, 16'h1001); poke(5, 16'h7777);
    start();
    wait_halt("loop_halt");
    chk("loop_fetch2", f2, 3);
    chk("loop_r1", o0_last, 16'h0000);
    chk("loop_count", o0_cnt, 1);
    // STR r5 -> [r4], LDR r6 <- [r4], OUTR r6
    rst = 1; ack_dly = 1;
    poke(0, 16'hC480); poke(1, 16'hC55C); poke(2, 16'h20A4); poke(3, 16'h18C4);
    poke(4, 16'h1006); poke(5, 16'h7777);
    start();
    wait_halt("rt_halt");
    chk("rt_mem", mem[8'h80], 16'h005C);
    chk("rt_out", o0_last, 16'h005C);
    // stalled OUTR, then asynchronous reset
    rst = 1; ack_dly = 0; o0_ready = 0;
    poke(0, 16'hC3A5); poke(1, 16'h1003); poke(2, 16'h7777);
    start();
    begin
      int n = 0;
      while (!o0_valid && n < 50) begin @(negedge clk); n++; end
    end
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, o0_valid}, 1);
      chk("stall_data", o0_data, 16'h00A5);
    end
    #2 rst = 1;
    #1 chk("async_drop", {o0_valid, m0_req}, 0);
    o0_ready = 1;
    start();
    begin
      int n = 0;
      while (!m0_req && n < 20) begin @(negedge clk); n++; end
    end
    chk("refetch_addr", {m0_req, m0_addr}, {1'b1, 16'h0000});
    // undefined opcode 5'b11111 at address 0
    @(negedge clk); rst = 1;
    poke(0, 16'hF800);
    start();
    repeat (12) @(negedge clk);
    chk("illegal_flags", {i0, h0, m0_req}, 3'b110);
    // all-NOP image: PC_W=4 core wraps from 15 to 0
    rst = 1; clr = 1;
    @(negedge clk); clr = 0;
    start();
    begin
      int n = 0;
      while (!(m2_req && m2_addr == 16'd15) && n < 100) begin @(negedge clk); n++; end
      chk("wrap_reach15", {m2_req, m2_addr}, {1'b1, 16'd15});
      n = 0;
      @(negedge clk);
      while (!m2_req && n < 10) begin @(negedge clk); n++; end
      chk("wrap_addr0", {m2_req, m2_addr}, {1'b1, 16'd0});
    end
    chk("protocol", viol, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
